// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter. ALU results take priority on the single write port.
// Cache load returns bypass or queue in order, and a pending vector tracks outstanding load destinations.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_dest,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_dest,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_dest,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      src_a,
  input  logic [4:0]      src_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            load,
  output logic [4:0]      dest,
  output logic [XLEN-1:0] in
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]      dest;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t              buf_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;

  logic ld_accept;
  logic alu_sel;
  logic head_sel;
  logic byp_sel;
  logic enq;
  logic deq;
  logic wb_any;
  logic wb_is_load;
  wb_t  wb_sel;

  // Readiness depends on registered occupancy only, never on ld_valid.
  assign ld_ready  = count < CNT_W'(DEPTH);
  assign ld_accept = ld_valid && ld_ready;

  assign alu_sel  = alu_valid && (alu_dest != 5'd0);
  assign head_sel = !alu_sel && (count != '0);
  assign byp_sel  = !alu_sel && (count == '0) && ld_accept;
  assign enq      = ld_accept && !byp_sel;
  assign deq      = head_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wb_sel     = '0;
    wb_any     = 1'b0;
    wb_is_load = 1'b0;
    if (alu_sel) begin
      wb_sel.dest = alu_dest;
      wb_sel.data = alu_data;
      wb_any      = 1'b1;
    end else if (head_sel) begin
      wb_sel     = buf_mem[rd_ptr];
      wb_any     = 1'b1;
      wb_is_load = 1'b1;
    end else if (byp_sel) begin
      wb_sel.dest = ld_dest;
      wb_sel.data = ld_data;
      wb_any      = 1'b1;
      wb_is_load  = 1'b1;
    end
  end

  // A new issue to the register being retired wins: a younger load is still outstanding.
  always_comb begin
    pending_nxt = pending;
    if (wb_is_load) pending_nxt[wb_sel.dest] = 1'b0;
    if (ld_issue)   pending_nxt[ld_issue_dest] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign busy_a = pending[src_a];
  assign busy_b = pending[src_b];

  // A load to x0 still occupies its selection slot but never writes, and dest/in hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    if (rst) begin
      load <= 1'b0;
      dest <= '0;
      in   <= '0;
    end else begin
      load <= wb_any && (wb_sel.dest != 5'd0);
      if (wb_any && (wb_sel.dest != 5'd0)) begin
        dest <= wb_sel.dest;
        in   <= wb_sel.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      pending <= pending_nxt;
    end
  end

  // NOTE: buffer storage is not reset; count and pointers gate every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (enq) buf_mem[wr_ptr] <= '{dest: ld_dest, data: ld_data};
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_dest;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_dest;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_dest;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      src_a;
  logic [4:0]      src_b;
  logic            busy_a;
  logic            busy_b;
  logic            load;
  logic [4:0]      dest;
  logic [XLEN-1:0] wb_in;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_dest (ld_issue_dest),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_dest       (ld_dest),
    .ld_data       (ld_data),
    .src_a         (src_a),
    .src_b         (src_b),
    .busy_a        (busy_a),
    .busy_b        (busy_b),
    .load          (load),
    .dest          (dest),
    .in            (wb_in)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, expected ready/busy during it, expected load/dest/in after the edge.
  typedef struct {
    int unsigned av, ad, adata, li, lid, lv, ld, ldata, sa, sb;
    int unsigned r, ba, bb, l, d, wd;
  } vec_t;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        m_q[$];
  logic [31:0] m_pending = '0;
  logic        m_load    = 1'b0;
  logic [4:0]  m_dest    = '0;
  logic [31:0] m_in      = '0;
  bit          m_acc     = 1'b0;
  logic [4:0]  iss_q[$];
  vec_t        vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input logic [4:0] d);
    foreach (iss_q[k]) if (iss_q[k] == d) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the reference behaviour, from the current inputs.
  task automatic model_step();
    bit          sel;
    bit          is_ld;
    bit          byp;
    logic [4:0]  wd;
    logic [31:0] wdata;
    ent_t        e;
    if (rst) begin
      m_q.delete();
      m_pending = '0;
      m_load = 1'b0;
      m_dest = '0;
      m_in = '0;
      m_acc = 1'b0;
      return;
    end
    assert (!(alu_valid && alu_dest != 5'd0 && m_pending[alu_dest]))
      else $error("protocol violation: ALU write to pending x%0d", alu_dest);
    m_acc = ld_valid && (m_q.size() < DEPTH);
    sel = 1'b0; is_ld = 1'b0; byp = 1'b0; wd = '0; wdata = '0;
    if (alu_valid && alu_dest != 5'd0) begin
      sel = 1'b1; wd = alu_dest; wdata = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      sel = 1'b1; is_ld = 1'b1; wd = e.dest; wdata = e.data;
    end else if (m_acc) begin
      sel = 1'b1; is_ld = 1'b1; byp = 1'b1; wd = ld_dest; wdata = ld_data;
    end
    if (m_acc && !byp) m_q.push_back('{ld_dest, ld_data});
    if (sel && wd != 5'd0) begin
      m_load = 1'b1; m_dest = wd; m_in = wdata;
    end else begin
      m_load = 1'b0;
    end
    if (is_ld) m_pending[wd] = 1'b0;
    if (ld_issue && ld_issue_dest != 5'd0) m_pending[ld_issue_dest] = 1'b1;
  endtask

  task automatic cycle(input string tag);
    #1;
    check({tag, " ld_ready"}, ld_ready, (m_q.size() < DEPTH));
    check({tag, " busy_a"}, busy_a, m_pending[src_a]);
    check({tag, " busy_b"}, busy_b, m_pending[src_b]);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " load"}, load, m_load);
    check({tag, " dest"}, dest, m_dest);
    check({tag, " in"}, wb_in, m_in);
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                       input logic li, input logic [4:0] lid,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldata,
                       input logic [4:0] sa, input logic [4:0] sb);
    alu_valid = av; alu_dest = ad; alu_data = adata;
    ld_issue = li; ld_issue_dest = lid;
    ld_valid = lv; ld_dest = ld; ld_data = ldata;
    src_a = sa; src_b = sb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         held;
    logic [4:0] d;

    // av,ad,adata, li,lid, lv,ld,ldata, sa,sb, ready,busy_a,busy_b, load,dest,in
    vt.push_back('{1, 5, 'h1234, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 1, 5, 'h1234});
    vt.push_back('{1, 0, 'h5555, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 5, 'h1234});
    vt.push_back('{0, 0, 0, 1, 7, 0, 0, 0, 7, 0, 1, 0, 0, 0, 5, 'h1234});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 5, 'h1234});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 5, 'h1234});
    vt.push_back('{0, 0, 0, 0, 0, 1, 7, 'hDEADBEEF, 7, 0, 1, 1, 0, 1, 7, 'hDEADBEEF});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 7, 'hDEADBEEF});
    vt.push_back('{0, 0, 0, 1, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0, 7, 'hDEADBEEF});
    vt.push_back('{1, 3, 'h33, 0, 0, 1, 4, 'h44, 0, 4, 1, 0, 1, 1, 3, 'h33});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 1, 4, 'h44});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 4, 'h44});
    vt.push_back('{0, 0, 0, 1, 8, 0, 0, 0, 8, 10, 1, 0, 0, 0, 4, 'h44});
    vt.push_back('{0, 0, 0, 1, 9, 0, 0, 0, 8, 10, 1, 1, 0, 0, 4, 'h44});
    vt.push_back('{0, 0, 0, 1, 10, 0, 0, 0, 8, 10, 1, 1, 0, 0, 4, 'h44});
    vt.push_back('{1, 1, 'h11, 0, 0, 1, 8, 'h88, 8, 10, 1, 1, 1, 1, 1, 'h11});
    vt.push_back('{1, 2, 'h22, 0, 0, 1, 9, 'h99, 8, 10, 1, 1, 1, 1, 2, 'h22});
    vt.push_back('{1, 11, 'hBB, 0, 0, 1, 10, 'hAA, 8, 10, 0, 1, 1, 1, 11, 'hBB});
    vt.push_back('{1, 12, 'hCC, 0, 0, 1, 10, 'hAA, 8, 10, 0, 1, 1, 1, 12, 'hCC});
    vt.push_back('{0, 0, 0, 0, 0, 1, 10, 'hAA, 8, 10, 0, 1, 1, 1, 8, 'h88});
    vt.push_back('{0, 0, 0, 0, 0, 1, 10, 'hAA, 8, 10, 1, 0, 1, 1, 9, 'h99});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8, 10, 1, 0, 1, 1, 10, 'hAA});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 8, 10, 1, 0, 0, 0, 10, 'hAA});
    vt.push_back('{0, 0, 0, 1, 6, 0, 0, 0, 6, 0, 1, 0, 0, 0, 10, 'hAA});
    vt.push_back('{1, 13, 'hD, 0, 0, 1, 6, 'h66, 6, 0, 1, 1, 0, 1, 13, 'hD});
    vt.push_back('{0, 0, 0, 1, 6, 0, 0, 0, 6, 0, 1, 1, 0, 1, 6, 'h66});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 0, 0, 6, 'h66});
    vt.push_back('{0, 0, 0, 0, 0, 1, 6, 'h67, 6, 0, 1, 1, 0, 1, 6, 'h67});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0, 6, 'h67});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 'h77, 0, 0, 1, 0, 0, 0, 6, 'h67});
    vt.push_back('{1, 0, 'h99, 0, 0, 1, 14, 'hEE, 0, 0, 1, 0, 0, 1, 14, 'hEE});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 14, 'hEE});

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      model_step();
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    check("reset load", load, 0);
    check("reset dest", dest, 0);
    check("reset in", wb_in, 0);
    check("reset ld_ready", ld_ready, 1);
    check("reset busy_a", busy_a, 0);

    foreach (vt[i]) begin
      drive(vt[i].av[0], vt[i].ad[4:0], vt[i].adata, vt[i].li[0], vt[i].lid[4:0],
            vt[i].lv[0], vt[i].ld[4:0], vt[i].ldata, vt[i].sa[4:0], vt[i].sb[4:0]);
      #1;
      check($sformatf("v%0d ld_ready", i), ld_ready, vt[i].r);
      check($sformatf("v%0d busy_a", i), busy_a, vt[i].ba);
      check($sformatf("v%0d busy_b", i), busy_b, vt[i].bb);
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("v%0d load", i), load, vt[i].l);
      check($sformatf("v%0d dest", i), dest, vt[i].d);
      check($sformatf("v%0d in", i), wb_in, vt[i].wd);
    end

    // Reset with two buffered loads and pending bits set.
    drive(0, 0, 0, 1, 20, 0, 0, 0, 20, 21); cycle("rs0");
    drive(0, 0, 0, 1, 21, 0, 0, 0, 20, 21); cycle("rs1");
    drive(1, 15, 1, 0, 0, 1, 20, 'h2020, 20, 21); cycle("rs2");
    drive(1, 16, 2, 0, 0, 1, 21, 'h2121, 20, 21); cycle("rs3");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 20, 21);
    #1;
    check("pre-rst ld_ready", ld_ready, 0);
    check("pre-rst busy_a", busy_a, 1);
    check("pre-rst busy_b", busy_b, 1);
    rst = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid-rst load", load, 0);
    check("mid-rst ld_ready", ld_ready, 1);
    check("mid-rst busy_a", busy_a, 0);
    check("mid-rst busy_b", busy_b, 0);
    for (int k = 0; k < 4; k++) begin
      cycle($sformatf("post-rst%0d", k));
      check($sformatf("post-rst%0d stale", k), load, 0);
    end

    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        iss_q.delete();
        held = 1'b0;
      end
      if (!held) begin
        ld_valid = 1'b0;
        ld_dest  = '0;
        ld_data  = $urandom;
        if (!rst && iss_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          ld_valid = 1'b1;
          ld_dest  = iss_q[0];
        end
      end
      ld_issue = 1'b0;
      ld_issue_dest = '0;
      if (!rst && $urandom_range(0, 2) == 0) begin
        d = 5'($urandom_range(0, 31));
        if (d == 5'd0 || (!m_pending[d] && !in_q(d))) begin
          ld_issue = 1'b1;
          ld_issue_dest = d;
        end
      end
      alu_valid = 1'($urandom_range(0, 1));
      alu_dest  = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      if (alu_dest != 5'd0 && (m_pending[alu_dest] || in_q(alu_dest) ||
          (ld_issue && ld_issue_dest == alu_dest)))
        alu_valid = 1'b0;
      src_a = (iss_q.size() > 0 && $urandom_range(0, 1) == 1) ? iss_q[0] : 5'($urandom_range(0, 31));
      src_b = 5'($urandom_range(0, 31));
      cycle($sformatf("rnd%0d", c));
      if (ld_issue && !rst) iss_q.push_back(ld_issue_dest);
      if (ld_valid && !m_acc && !rst) begin
        held = 1'b1;
      end else begin
        held = 1'b0;
        if (ld_valid && m_acc) void'(iss_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sole driver of the register file write port (`load`, `dest`, `in`).
- Merges two result producers onto that single port:
  - the single-cycle ALU pipeline, which has priority;
  - the variable-latency load path returning from the L1 data cache, which may be buffered.
- Keeps a pending-load scoreboard so decode can stall on source registers whose load result has not yet been written.

Parameters:
- DEPTH, 2: number of entries in the load-result buffer (power of two, ≥2).
- XLEN, 32: data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- alu_valid  input  1  ALU result present this cycle (never stalled).
- alu_dest  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- ld_issue  input  1  a load is leaving issue; reserve its destination.
- ld_issue_dest  input  5  destination of the issuing load.
- ld_valid  input  1  cache load result valid.
- ld_ready  output  1  arbiter can accept a load result.
- ld_dest  input  5  load destination register.
- ld_data  input  XLEN  load result.
- src_a  input  5  decode source register A.
- src_b  input  5  decode source register B.
- busy_a  output  1  src_a has an outstanding load.
- busy_b  output  1  src_b has an outstanding load.
- load  output  1  register file write enable (registered).
- dest  output  5  register file write index (registered).
- in  output  XLEN  register file write data (registered).

Behaviour:
- Reset: clears `load`, `dest`, `in` to 0, the buffer (count=0, rd_ptr=wr_ptr=0) and the pending vector (all 0). `ld_ready`=1 the cycle after reset. Reset mid-operation discards buffered and in-flight results.
- Load handshake:
  - A load is accepted when `ld_valid` && `ld_ready`.
  - `ld_ready` = (count < DEPTH), computed from registered count only, with no combinational path from `ld_valid`.
  - Producer holds `ld_dest`/`ld_data` stable while `ld_valid` && !`ld_ready`.
- Write selection each cycle, at most one, priority order:
  1. `alu_valid` with `alu_dest`≠0.
  2. Buffer head (count>0).
  3. Accepted incoming load, bypassing the buffer, only when count==0.
- The selected write is registered. `load`/`dest`/`in` show it the next cycle: latency exactly 1 cycle from selection.
- No write selected: `load`=0 next cycle; `dest`/`in` hold their previous values.
- Buffer enqueue: an accepted load that is not selected in the same cycle goes to wr_ptr, which advances mod DEPTH.
- Buffer dequeue: when the head is selected, rd_ptr advances mod DEPTH.
- Count: enqueue and dequeue in the same cycle leave count unchanged. Count never exceeds DEPTH.
- Loads complete in acceptance order; buffered loads are never reordered.
- Destination x0:
  - ALU result to x0 is ignored and does not consume the port.
  - Load result to x0 is accepted and still passes through the buffer or selection, but produces `load`=0 when it is the selected write.
- Scoreboard (32-bit pending vector):
  - Set: `ld_issue` && `ld_issue_dest`≠0 sets `pending[ld_issue_dest]`.
  - Clear: selecting a load write (buffered or bypass) clears `pending[that dest]`.
  - Set and clear of the same register in one cycle: set wins, because a newer load is outstanding.
  - `pending[0]` is constantly 0.
- busy outputs:
  - `busy_a` = `pending[src_a]` and `busy_b` = `pending[src_b]`, combinational from registered state.
  - busy stays high through the cycle in which the write is registered. It drops the cycle `load` asserts; the register file's write bypass covers that cycle.
- Ordering contract:
  - Issue logic never issues an ALU op whose dest is pending.
  - An ALU write to a pending dest is a protocol violation, flagged by a bench assertion. There is no RTL recovery.

Test Plan:
- ALU only: `alu_valid` with dest=5, data=0x1234 in cycle 0 → cycle 1 `load`=1, `dest`=5, `in`=0x1234. `alu_dest`=0 → `load`=0.
- Load bypass: `ld_issue` dest=7; `busy_a`=1 with `src_a`=7. 3 cycles later `ld_valid` with data=0xDEADBEEF, no ALU → next cycle `load`=1, `dest`=7, `in`=0xDEADBEEF, `busy_a`=0 that same cycle.
- Conflict: ALU (dest 3) and load (dest 4) valid together → cycle+1 writes x3. The load is buffered with count=1. Cycle+2 writes x4 if ALU idle.
- Backpressure, DEPTH=2: ALU valid every cycle while loads arrive to x8, x9, x10 → `ld_ready`=0 after two enqueues, the third is held. When the ALU idles, writes emerge x8, x9, x10 in order.
- Simultaneous set/clear: a buffered load to x6 is written in the same cycle a new load to x6 issues → `pending[6]` stays 1 and `busy` remains high until the second load writes.
- Reset mid-operation: two buffered loads plus pending bits set, assert `rst` 1 cycle → `load`=0, `ld_ready`=1, all busy=0, no stale writes afterward.
